// File: rtl/ex_mul_stage.sv
// ex_mul_stage: RV32 execute stage with an optional iterative multiplier (build option EX_MUL_EN).
// Latency: 1 edge for single-cycle ops; MUL result on edge K+1 after issue (K = 32/MUL_BITS_PER_CYCLE).
// Backpressure: mem_stall freezes the output bus; stall_out holds ID/EX while stalled or mid-MUL.
// Ports: clock, reset (async, active-high); in_valid, instruction, opcode, funct3, funct7, rd,
//   a_val, b_val, imm from ID/EX; mem_stall from MEM; excpt_in (nonzero = flush);
//   ex_mem_bus_out and illegal_op (registered) to EX/MEM; stall_out to the upstream stage.
// Without EX_MUL_EN, funct7=0000001 R-type ops are flagged illegal in one cycle and the FSM stays IDLE.

package ex_mul_stage_pkg;
  typedef struct packed {
    logic [31:0] instruction;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] b_val;
  } ex_mem_bus_t;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LW = 7'b0000011;
  localparam logic [6:0] OPC_SW = 7'b0100011;
endpackage

module ex_mul_stage
  import ex_mul_stage_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] instruction,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [31:0] a_val,
  input  logic [31:0] b_val,
  input  logic [31:0] imm,
  input  logic        mem_stall,
  input  logic [2:0]  excpt_in,
  output ex_mem_bus_t ex_mem_bus_out,
  output logic        stall_out,
  output logic        illegal_op
);

  if (!(MUL_BITS_PER_CYCLE == 1 || MUL_BITS_PER_CYCLE == 2 || MUL_BITS_PER_CYCLE == 4 ||
        MUL_BITS_PER_CYCLE == 8 || MUL_BITS_PER_CYCLE == 16 || MUL_BITS_PER_CYCLE == 32))
  begin : g_bad_width
    $error("MUL_BITS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
  end

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

  state_t      state_q, state_d;
  ex_mem_bus_t bus_q, bus_d;
  logic        ill_q, ill_d;

  // Shared ALU; alt selects SUB for funct3=000 and arithmetic shift for funct3=101.
  function automatic logic [31:0] alu_fn(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b, input logic alt);
    logic [31:0] r;
    r = '0;
    case (f3)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'd0, $signed(a) < $signed(b)};
      3'b011:  r = {31'd0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  logic [31:0] alu_res;
  logic        alu_ill;
  ex_mem_bus_t res_bus;
`ifdef EX_MUL_EN
  logic        is_mul;
`endif

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
`ifdef EX_MUL_EN
    is_mul  = 1'b0;
`endif
    case (opcode)
      OPC_R: begin
        if (funct7 == 7'b0000001) begin
`ifdef EX_MUL_EN
          is_mul  = (funct3 == 3'b000);
          alu_ill = (funct3 != 3'b000);
`else
          alu_ill = 1'b1;
`endif
        end else begin
          alu_res = alu_fn(funct3, a_val, b_val, funct7[5]);
        end
      end
      // I-type: no SUB; imm[10] distinguishes SRAI from SRLI.
      OPC_I:          alu_res = alu_fn(funct3, a_val, imm, (funct3 == 3'b101) && imm[10]);
      OPC_LW, OPC_SW: alu_res = a_val + imm;
      // Unknown opcodes are passed through with an address-style sum.
      default:        alu_res = a_val + imm;
    endcase
    res_bus = '{instruction: instruction, opcode: opcode, funct3: funct3, rd: rd,
                alu_result: alu_res, b_val: b_val};
  end

`ifdef EX_MUL_EN
  localparam int K      = 32 / MUL_BITS_PER_CYCLE;
  localparam int ITER_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [ITER_W-1:0] LAST = ITER_W'(K - 1);

  logic [31:0]       ma_q, ma_d, mb_q, mb_d, acc_q, acc_d, minstr_q, minstr_d;
  logic [4:0]        mrd_q, mrd_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [4:0]        sh;
  logic [31:0]       digit, acc_sum, prod;
  ex_mem_bus_t       mul_bus;

  // One radix-2^MUL_BITS_PER_CYCLE digit of the multiplier per iteration, low digit first.
  always_comb begin
    sh    = 5'(32'(iter_q) * MUL_BITS_PER_CYCLE);
    digit = '0;
    digit[MUL_BITS_PER_CYCLE-1:0] = mb_q[sh +: MUL_BITS_PER_CYCLE];
    acc_sum = acc_q + ((ma_q * digit) << sh);
    // In HOLD the finished product already sits in the accumulator.
    prod    = (state_q == S_HOLD) ? acc_q : acc_sum;
    mul_bus = '{instruction: minstr_q, opcode: OPC_R, funct3: 3'b000, rd: mrd_q,
                alu_result: prod, b_val: mb_q};
  end

  assign stall_out = mem_stall | ((state_q == S_IDLE) && in_valid && is_mul) |
                     ((state_q == S_MUL) && (iter_q != LAST));
`else
  assign stall_out = mem_stall;
`endif

  always_comb begin
    state_d  = state_q;
    bus_d    = bus_q;
    ill_d    = ill_q;
`ifdef EX_MUL_EN
    ma_d     = ma_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    iter_d   = iter_q;
    minstr_d = minstr_q;
    mrd_d    = mrd_q;
`endif
    if (excpt_in != 3'b000) begin
      // Flush wins over everything, including mem_stall.
      state_d = S_IDLE;
      bus_d   = '0;
      ill_d   = 1'b0;
    end else begin
      case (state_q)
`ifdef EX_MUL_EN
        S_MUL: begin
          acc_d  = acc_sum;
          iter_d = iter_q + ITER_W'(1);
          if (iter_q == LAST) begin
            if (mem_stall) begin
              state_d = S_HOLD;
            end else begin
              state_d = S_IDLE;
              bus_d   = mul_bus;
              ill_d   = 1'b0;
            end
          end else if (!mem_stall) begin
            // Keep MEM fed with bubbles so the previous instruction is not replayed.
            bus_d = '0;
            ill_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!mem_stall) begin
            state_d = S_IDLE;
            bus_d   = mul_bus;
            ill_d   = 1'b0;
          end
        end
`endif
        default: begin
          if (!mem_stall) begin
`ifdef EX_MUL_EN
            if (in_valid && is_mul) begin
              state_d  = S_MUL;
              ma_d     = a_val;
              mb_d     = b_val;
              acc_d    = '0;
              iter_d   = '0;
              minstr_d = instruction;
              mrd_d    = rd;
              bus_d    = '0;
              ill_d    = 1'b0;
            end else
`endif
            if (in_valid) begin
              bus_d = res_bus;
              ill_d = alu_ill;
            end else begin
              bus_d = '0;
              ill_d = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bus_q    <= '0;
      ill_q    <= 1'b0;
`ifdef EX_MUL_EN
      ma_q     <= '0;
      mb_q     <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
      minstr_q <= '0;
      mrd_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      bus_q    <= bus_d;
      ill_q    <= ill_d;
`ifdef EX_MUL_EN
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      acc_q    <= acc_d;
      iter_q   <= iter_d;
      minstr_q <= minstr_d;
      mrd_q    <= mrd_d;
`endif
    end
  end

  assign ex_mem_bus_out = bus_q;
  assign illegal_op     = ill_q;

endmodule

// File: tb/tb_ex_mul_stage.sv
// tb_ex_mul_stage: directed vectors for ex_mul_stage with a queue-based scoreboard.
// Each step drives one cycle of inputs and queues what the outputs must show at that cycle's
// falling edge; a separate monitor pops and compares.
module tb_ex_mul_stage;
  import ex_mul_stage_pkg::*;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] XO = 7'b1111111;
  localparam logic [6:0] F0 = 7'b0000000;
  localparam logic [6:0] FA = 7'b0100000;
  localparam logic [6:0] FM = 7'b0000001;
`ifdef EX_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [4:0]  rd = '0;
  logic [31:0] a_val = '0, b_val = '0, imm = '0;
  logic        mem_stall = 1'b0;
  logic [2:0]  excpt_in = '0;
  ex_mem_bus_t bus_out;
  logic        stall_out, illegal_op;

  ex_mul_stage #(.MUL_BITS_PER_CYCLE(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .instruction(instruction),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .a_val(a_val),
    .b_val(b_val), .imm(imm), .mem_stall(mem_stall), .excpt_in(excpt_in),
    .ex_mem_bus_out(bus_out), .stall_out(stall_out), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        st;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", nm, fld, act, want);
    end
  endtask

  always @(negedge clock) begin : monitor
    exp_t  e;
    string nm;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk(nm, "stall_out", {31'd0, stall_out}, {31'd0, e.st});
      chk(nm, "alu_result", bus_out.alu_result, e.res);
      chk(nm, "rd", {27'd0, bus_out.rd}, {27'd0, e.rd});
      chk(nm, "illegal_op", {31'd0, illegal_op}, {31'd0, e.ill});
    end
  end

  // Drive one cycle just after the rising edge and queue the expected outputs for this cycle.
  task automatic step(input logic v, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rdi, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] im, input logic ms,
                      input logic [2:0] ex, input string nm, input logic est,
                      input logic [31:0] eres, input logic [4:0] erd, input logic eill);
    @(posedge clock);
    #1;
    in_valid = v; opcode = op; funct3 = f3; funct7 = f7; rd = rdi;
    a_val = a; b_val = b; imm = im; mem_stall = ms; excpt_in = ex;
    instruction = {f7, 10'd0, f3, rdi, op};
    exp_q.push_back('{est, eres, erd, eill});
    name_q.push_back(nm);
  endtask

  task automatic nop(input logic ms, input logic [2:0] ex, input string nm, input logic est,
                     input logic [31:0] eres, input logic [4:0] erd, input logic eill);
    step(0, 7'd0, 3'd0, F0, 5'd0, 0, 0, 0, ms, ex, nm, est, eres, erd, eill);
  endtask

  initial begin
    nop(0, 0, "reset", 0, 0, 0, 0);
    step(1, R, 3'b000, F0, 5'd1, 32'h7FFFFFFF, 1, 0, 0, 0, "add_issue", 0, 0, 0, 0);
    reset = 1'b0;
    nop(0, 0, "add", 0, 32'h80000000, 5'd1, 0);
    step(1, R, 3'b000, FA, 5'd2, 5, 7, 0, 0, 0, "bubble", 0, 0, 0, 0);
    step(1, R, 3'b010, F0, 5'd3, 32'hFFFFFFFF, 1, 0, 0, 0, "sub", 0, 32'hFFFFFFFE, 5'd2, 0);
    step(1, R, 3'b011, F0, 5'd4, 32'hFFFFFFFF, 1, 0, 0, 0, "slt", 0, 1, 5'd3, 0);
    step(1, R, 3'b101, FA, 5'd5, 32'h80000000, 32'h24, 0, 0, 0, "sltu", 0, 0, 5'd4, 0);
    step(1, I, 3'b101, F0, 5'd6, 32'h80000000, 0, 32'h404, 0, 0, "sra", 0, 32'hF8000000, 5'd5, 0);
    step(1, I, 3'b101, F0, 5'd7, 32'h80000000, 0, 4, 0, 0, "srai", 0, 32'hF8000000, 5'd6, 0);
    step(1, LD, 3'b010, F0, 5'd8, 32'h100, 32'h55, 8, 0, 0, "srli", 0, 32'h08000000, 5'd7, 0);
    step(1, I, 3'b000, F0, 5'd9, 1, 0, 32'hFFFFFFFF, 1, 0, "lw", 1, 32'h108, 5'd8, 0);
    step(1, I, 3'b000, F0, 5'd9, 1, 0, 32'hFFFFFFFF, 1, 0, "lw_hold1", 1, 32'h108, 5'd8, 0);
    step(1, I, 3'b000, F0, 5'd9, 1, 0, 32'hFFFFFFFF, 1, 0, "lw_hold2", 1, 32'h108, 5'd8, 0);
    step(1, I, 3'b000, F0, 5'd9, 1, 0, 32'hFFFFFFFF, 0, 0, "lw_hold3", 0, 32'h108, 5'd8, 0);
    step(1, XO, 3'b000, F0, 5'd12, 3, 0, 4, 0, 0, "addi", 0, 0, 5'd9, 0);
    step(1, R, 3'b000, F0, 5'd13, 1, 2, 0, 0, 0, "passthru", 0, 7, 5'd12, 0);
    nop(1, 3'b010, "add2", 1, 3, 5'd13, 0);
    nop(0, 0, "flush_stall", 0, 0, 0, 0);
    step(1, R, 3'b000, FM, 5'd10, 32'hFFFFFFFF, 3, 0, 0, 0, "mul_issue", MUL_EN, 0, 0, 0);
`ifdef EX_MUL_EN
    step(1, R, 3'b000, FM, 5'd10, 32'hFFFFFFFF, 3, 0, 0, 0, "mul_it0", 1, 0, 0, 0);
    step(1, R, 3'b000, FM, 5'd10, 32'hFFFFFFFF, 3, 0, 0, 0, "mul_it1", 1, 0, 0, 0);
    step(1, R, 3'b000, FM, 5'd10, 32'hFFFFFFFF, 3, 0, 0, 0, "mul_it2", 1, 0, 0, 0);
    step(1, R, 3'b000, FM, 5'd10, 32'hFFFFFFFF, 3, 0, 0, 0, "mul_last", 0, 0, 0, 0);
    nop(0, 0, "mul", 0, 32'hFFFFFFFD, 5'd10, 0);
    step(1, R, 3'b000, FM, 5'd11, 7, 6, 0, 0, 0, "hold_issue", 1, 0, 0, 0);
    step(1, R, 3'b000, FM, 5'd11, 7, 6, 0, 0, 0, "hold_it0", 1, 0, 0, 0);
    step(1, R, 3'b000, FM, 5'd11, 7, 6, 0, 0, 0, "hold_it1", 1, 0, 0, 0);
    step(1, R, 3'b000, FM, 5'd11, 7, 6, 0, 0, 0, "hold_it2", 1, 0, 0, 0);
    step(1, R, 3'b000, FM, 5'd11, 7, 6, 0, 1, 0, "hold_last", 1, 0, 0, 0);
    step(1, R, 3'b000, FM, 5'd11, 7, 6, 0, 1, 0, "hold_wait", 1, 0, 0, 0);
    step(1, R, 3'b000, FM, 5'd11, 7, 6, 0, 0, 0, "hold_rel", 0, 0, 0, 0);
    nop(0, 0, "hold_mul", 0, 42, 5'd11, 0);
    step(1, R, 3'b000, FM, 5'd12, 2, 3, 0, 0, 0, "flush_issue", 1, 0, 0, 0);
    step(1, R, 3'b000, FM, 5'd12, 2, 3, 0, 0, 0, "flush_it0", 1, 0, 0, 0);
    step(1, R, 3'b000, FM, 5'd12, 2, 3, 0, 0, 0, "flush_it1", 1, 0, 0, 0);
    step(1, R, 3'b000, FM, 5'd12, 2, 3, 0, 0, 3'b001, "flush_it2", 1, 0, 0, 0);
    nop(0, 0, "flush_idle", 0, 0, 0, 0);
    step(1, R, 3'b000, F0, 5'd13, 1, 2, 0, 0, 0, "post_flush", 0, 0, 0, 0);
    nop(0, 0, "post_flush_add", 0, 3, 5'd13, 0);
`else
    step(1, R, 3'b001, FM, 5'd11, 32'hFFFFFFFF, 3, 0, 0, 0, "mul_ill", 0, 0, 5'd10, 1);
    nop(0, 0, "mulh_ill", 0, 0, 5'd11, 1);
`endif
    step(1, R, 3'b000, F0, 5'd14, 5, 5, 0, 0, 0, "pre_rst", 0, 0, 0, 0);
    step(1, R, 3'b000, F0, 5'd15, 6, 6, 0, 0, 0, "pre_rst_add", 0, 10, 5'd14, 0);
    nop(0, 0, "async_rst", 0, 0, 0, 0);
    reset = 1'b1;
    nop(0, 0, "rst_held", 0, 0, 0, 0);
    reset = 1'b0;
    step(1, R, 3'b000, F0, 5'd16, 9, 9, 0, 0, 0, "post_rst", 0, 0, 0, 0);
    nop(0, 0, "post_rst_add", 0, 18, 5'd16, 0);
    @(negedge clock);
    #1;
    chk("scoreboard", "pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ex_mul_stage.md
EX_MUL_STAGE -- requirements
Module: ex_mul_stage

Interface
- REQ-001 SHALL have parameter MUL_BITS_PER_CYCLE, default 8: multiplier bits retired per iteration; legal values are 1, 2, 4, 8, 16 and 32; K = 32/MUL_BITS_PER_CYCLE.
- REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
- REQ-004 SHALL have port in_valid, input, 1 bit: the ID/EX register holds a valid instruction.
- REQ-005 SHALL have ports instruction (input, 32), opcode (input, 7), funct3 (input, 3), funct7 (input, 7) and rd (input, 5): the decoded instruction fields.
- REQ-006 SHALL have ports a_val, b_val and imm, each input, 32 bits: rs1 value, rs2 value and sign-extended immediate.
- REQ-007 SHALL have port mem_stall, input, 1 bit: the MEM stage stall output.
- REQ-008 SHALL have port excpt_in, input, 3 bits: any nonzero value means flush.
- REQ-009 SHALL have port ex_mem_bus_out, output, ex_mem_bus_t: registered fields instruction, opcode, funct3, rd, alu_result and b_val.
- REQ-010 SHALL have port stall_out, output, 1 bit: upstream must hold ID/EX when this is high.
- REQ-011 SHALL have port illegal_op, output, 1 bit: registered, travels with the bus.

Function
- REQ-012 SHALL execute ALUopR ops combinationally in one cycle:
  - ADD, or SUB when funct7[5]=1
  - SLL, SLT, SLTU, XOR
  - SRL, or SRA when funct7[5]=1
  - OR, AND
  - shift amounts use b_val[4:0]; all results wrap modulo 2^32.
- REQ-013 SHALL execute ALUopI with imm substituted for b_val; SUB is not applicable; SRAI is selected by imm[10].
- REQ-014 SHALL compute alu_result = a_val + imm for LW and SW, and SHALL pass b_val and funct3 through unchanged.
- REQ-015 SHALL treat ALUopR with funct7 = 0000001 and funct3 = 000 as MUL: alu_result = low 32 bits of a_val*b_val.
- REQ-016 SHALL flag every other funct7 = 0000001 encoding as illegal: illegal_op=1, alu_result=0.
- REQ-017 SHALL implement FSM states IDLE, MUL and HOLD.
- REQ-018 SHALL transition from IDLE to MUL when in_valid=1, the op is MUL, mem_stall=0 and excpt_in=0.
  - On that transition it SHALL latch the operands, clear the accumulator and set iter=0.
- REQ-019 SHALL, in MUL state, add one partial product of MUL_BITS_PER_CYCLE multiplier bits per cycle and increment iter.
  - The last iteration is iter = K-1.
- REQ-020 SHALL, on the last iteration with mem_stall=0, load the product into ex_mem_bus_out and return to IDLE.
- REQ-021 SHALL, on the last iteration with mem_stall=1, keep the product in HOLD.
  - It SHALL then load the product in the first cycle with mem_stall=0 and return to IDLE.
- REQ-022 SHALL drive stall_out = mem_stall OR (IDLE AND in_valid AND MUL) OR (MUL AND iter != K-1).
- REQ-023 SHALL give MUL this timing:
  - stall_out is high for exactly K cycles when mem_stall=0.
  - The product is visible K+1 edges after MUL is first presented.
- REQ-024 SHALL, when mem_stall=1, hold ex_mem_bus_out and illegal_op unchanged.
- REQ-025 SHALL, when mem_stall=0 and in IDLE, load the bus at each edge:
  - with the single-cycle result when in_valid=1 and the op is not MUL;
  - with a bubble (all fields zero, illegal_op=0) when in_valid=0.
- REQ-026 SHALL, when excpt_in is nonzero, override all other events:
  - load a bubble at the edge, even if mem_stall=1;
  - abort any MUL or HOLD and go to IDLE.
- REQ-027 SHALL treat an unrecognised opcode as pass-through: alu_result = a_val + imm, illegal_op=0.

Reset
- REQ-028 SHALL, while reset=1, immediately set all ex_mem_bus_out fields to 0, illegal_op=0, state=IDLE, iter=0 and the accumulator to 0, independent of clock.
- REQ-029 SHALL, when reset is asserted mid-MUL or in HOLD, discard the product; the first edge after release behaves as from IDLE.

Configuration
- REQ-030 SHALL include the iterative multiplier, states MUL/HOLD and REQ-015, REQ-018 to REQ-023 when EX_MUL_EN is defined.
- REQ-031 SHALL, when EX_MUL_EN is undefined:
  - treat every funct7 = 0000001 ALUopR encoding per REQ-016 (illegal_op=1, alu_result=0, single cycle);
  - keep the FSM permanently in IDLE;
  - drive stall_out = mem_stall.

Verification
- REQ-032 SHALL cover ADD: a_val=0x7FFFFFFF, b_val=1 -> alu_result=0x80000000 after 1 edge, stall_out=0.
- REQ-033 SHALL cover LW with mem_stall=1 for 3 cycles:
  - ADDI after LW -> bus holds the LW result (a_val=0x100, imm=8 -> 0x108) for 3 cycles;
  - the ADDI result loads on the edge after mem_stall falls.
- REQ-034 SHALL cover MUL with EX_MUL_EN and K=4: a_val=0xFFFFFFFF, b_val=3 -> stall_out high 4 cycles; alu_result=0xFFFFFFFD on the 5th edge.
- REQ-035 SHALL cover MUL completing with mem_stall=1 for 2 cycles: state HOLD; the product loads on the first edge with mem_stall=0.
- REQ-036 SHALL cover excpt_in=3'b001 at MUL iter=2 -> bubble on the next edge, state IDLE, stall_out=mem_stall.
- REQ-037 SHALL cover MUL built without EX_MUL_EN -> illegal_op=1, alu_result=0, stall_out=0, loaded after 1 edge.
